// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared encodings and default widths for the pipelined CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int REG_ADDR_W_DEF = 5;

    // Encoding 2'b11 is reserved and behaves as a full word access.
    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
//  Module      : load_align
//  Description : Little-endian sub-word load extraction with zero/sign extend.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_byte_fill;
    logic        w_half_fill;

    assign w_byte      = word[{addr_lo, 3'b000} +: 8];
    // Halves ignore addr_lo[0]: misaligned halves read the aligned lane.
    assign w_half      = word[{addr_lo[1], 4'b0000} +: 16];
    assign w_byte_fill = ~is_unsigned & w_byte[7];
    assign w_half_fill = ~is_unsigned & w_half[15];

    always_comb begin
        value = word;
        case (size)
            MEM_BYTE: value = {{(DATA_W-8){w_byte_fill}}, w_byte};
            MEM_HALF: value = {{(DATA_W-16){w_half_fill}}, w_half};
            default:  value = word;
        endcase
    end

endmodule : load_align

`default_nettype wire

// File: rtl/mem_wb_pipe_reg.sv
// ============================================================================
//  Module      : mem_wb_pipe_reg
//  Description : MEM/WB pipeline register with stall/flush, load alignment,
//                write-back select, forwarding enable and bubble counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_pipe_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic [1:0]            mem_size_in,
    input  logic                  mem_unsigned_in,
    input  logic [1:0]            addr_lo_in,
    input  logic [DATA_W-1:0]     read_data_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [REG_ADDR_W-1:0] write_reg_in,
    output logic                  valid_out,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out,
    output logic [DATA_W-1:0]     read_data_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [REG_ADDR_W-1:0] write_reg_out,
    output logic [DATA_W-1:0]     wb_data_out,
    output logic                  fwd_en_out,
    output logic [CNT_W-1:0]      bubble_cnt_out
);

    logic                  r_valid;
    logic                  r_reg_write;
    logic                  r_mem_to_reg;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [1:0]            r_addr_lo;
    logic [DATA_W-1:0]     r_read_data;
    logic [DATA_W-1:0]     r_alu_result;
    logic [REG_ADDR_W-1:0] r_write_reg;
    logic [CNT_W-1:0]      r_bubble_cnt;

    logic                  w_valid_nxt;
    logic                  w_bubble_inc;
    logic [DATA_W-1:0]     w_load_val;

    // Flush only kills the instruction; payload fields are kept so a
    // flushed slot still shows its last data for debug visibility.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_write_reg  <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
        end else if (!stall) begin
            r_valid      <= valid_in;
            r_reg_write  <= reg_write_in;
            r_mem_to_reg <= mem_to_reg_in;
            r_size       <= mem_size_in;
            r_unsigned   <= mem_unsigned_in;
            r_addr_lo    <= addr_lo_in;
            r_read_data  <= read_data_in;
            r_alu_result <= alu_result_in;
            r_write_reg  <= write_reg_in;
        end
    end

    assign w_valid_nxt  = flush ? 1'b0 : (stall ? r_valid : valid_in);
    assign w_bubble_inc = ~stall & ~w_valid_nxt & ~(&r_bubble_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble_inc) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .word        (r_read_data),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .addr_lo     (r_addr_lo),
        .value       (w_load_val)
    );

    assign valid_out      = r_valid;
    assign reg_write_out  = r_valid & r_reg_write & (r_write_reg != '0);
    assign fwd_en_out     = reg_write_out;
    assign mem_to_reg_out = r_mem_to_reg;
    assign read_data_out  = r_read_data;
    assign alu_result_out = r_alu_result;
    assign write_reg_out  = r_write_reg;
    assign wb_data_out    = r_mem_to_reg ? w_load_val : r_alu_result;
    assign bubble_cnt_out = r_bubble_cnt;

endmodule : mem_wb_pipe_reg

`default_nettype wire

// File: tb/tb_mem_wb_pipe_reg.sv
// ============================================================================
//  Module      : tb_mem_wb_pipe_reg
//  Description : Directed self-checking bench with a behavioural stage model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_pipe_reg;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0, flush = 1'b0;
    logic          valid_in = 1'b0, reg_write_in = 1'b0, mem_to_reg_in = 1'b0;
    logic [1:0]    mem_size_in = 2'b00, addr_lo_in = 2'b00;
    logic          mem_unsigned_in = 1'b0;
    logic [DW-1:0] read_data_in = '0, alu_result_in = '0;
    logic [AW-1:0] write_reg_in = '0;

    logic          valid_out, reg_write_out, mem_to_reg_out, fwd_en_out;
    logic [DW-1:0] read_data_out, alu_result_out, wb_data_out;
    logic [AW-1:0] write_reg_out;
    logic [CW-1:0] bubble_cnt_out;

    int vectors = 0;
    int miscompares = 0;

    mem_wb_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .valid_in       (valid_in),
        .reg_write_in   (reg_write_in),
        .mem_to_reg_in  (mem_to_reg_in),
        .mem_size_in    (mem_size_in),
        .mem_unsigned_in(mem_unsigned_in),
        .addr_lo_in     (addr_lo_in),
        .read_data_in   (read_data_in),
        .alu_result_in  (alu_result_in),
        .write_reg_in   (write_reg_in),
        .valid_out      (valid_out),
        .reg_write_out  (reg_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .write_reg_out  (write_reg_out),
        .wb_data_out    (wb_data_out),
        .fwd_en_out     (fwd_en_out),
        .bubble_cnt_out (bubble_cnt_out)
    );

    always #5 clk = ~clk;

    // Behavioural model of the stage contents
    logic          m_valid = 0, m_rw = 0, m_m2r = 0, m_uns = 0;
    logic [1:0]    m_size = 0, m_lo = 0;
    logic [DW-1:0] m_rd = 0, m_alu = 0;
    logic [AW-1:0] m_wr = 0;
    int            m_cnt = 0;

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic uns, input logic [1:0] lo);
        logic [31:0] v;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * int'(lo);
            v = (w >> sh) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            sh = lo[1] ? 16 : 0;
            v = (w >> sh) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic nv;
        if (rst) begin
            m_valid = 0; m_rw = 0; m_m2r = 0; m_uns = 0; m_size = 0; m_lo = 0;
            m_rd = 0; m_alu = 0; m_wr = 0; m_cnt = 0;
        end else begin
            nv = flush ? 1'b0 : (stall ? m_valid : valid_in);
            if (!stall && !nv && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (flush) begin
                m_valid = 0; m_rw = 0;
            end else if (!stall) begin
                m_valid = valid_in; m_rw = reg_write_in; m_m2r = mem_to_reg_in;
                m_size = mem_size_in; m_uns = mem_unsigned_in; m_lo = addr_lo_in;
                m_rd = read_data_in; m_alu = alu_result_in; m_wr = write_reg_in;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic exp_we;
        exp_we = m_valid && m_rw && (m_wr != 0);
        check("valid_out",      32'(valid_out),      32'(m_valid));
        check("reg_write_out",  32'(reg_write_out),  32'(exp_we));
        check("fwd_en_out",     32'(fwd_en_out),     32'(exp_we));
        check("mem_to_reg_out", 32'(mem_to_reg_out), 32'(m_m2r));
        check("read_data_out",  read_data_out,       m_rd);
        check("alu_result_out", alu_result_out,      m_alu);
        check("write_reg_out",  32'(write_reg_out),  32'(m_wr));
        check("wb_data_out",    wb_data_out,
              m_m2r ? extract(m_rd, m_size, m_uns, m_lo) : m_alu);
        check("bubble_cnt_out", 32'(bubble_cnt_out), 32'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sz, input logic uns, input logic [1:0] lo,
                        input logic [31:0] rd, input logic [AW-1:0] wr);
        valid_in = 1; reg_write_in = 1; mem_to_reg_in = 1;
        mem_size_in = sz; mem_unsigned_in = uns; addr_lo_in = lo;
        read_data_in = rd; write_reg_in = wr;
    endtask

    int cnt_saved;

    initial begin
        repeat (2) step();
        check("reset_valid", 32'(valid_out), 32'h0);
        check("reset_cnt",   32'(bubble_cnt_out), 32'h0);
        rst = 0;

        // Word pass-through
        load(2'b10, 0, 2'b00, 32'hDEADBEEF, 5'd7);
        step();
        check("word_wb", wb_data_out, 32'hDEADBEEF);
        check("word_we", 32'(reg_write_out), 32'h1);
        check("word_fwd", 32'(fwd_en_out), 32'h1);

        // Sub-word loads with hand-computed results
        load(2'b00, 0, 2'd3, 32'h80FF7F01, 5'd9); step();
        check("byte3_s", wb_data_out, 32'hFFFFFF80);
        load(2'b00, 1, 2'd0, 32'h80FF7F01, 5'd9); step();
        check("byte0_u", wb_data_out, 32'h00000001);
        load(2'b01, 0, 2'd2, 32'h80FF7F01, 5'd9); step();
        check("half2_s", wb_data_out, 32'hFFFF80FF);
        load(2'b01, 1, 2'd0, 32'h80FF7F01, 5'd9); step();
        check("half0_u", wb_data_out, 32'h00007F01);

        // Sweep every size/lane/sign combination against the model
        for (int sz = 0; sz < 4; sz++)
            for (int lo = 0; lo < 4; lo++)
                for (int u = 0; u < 2; u++) begin
                    load(2'(sz), 1'(u), 2'(lo), 32'h80FF7F01 ^ (32'(lo) << 12), 5'(lo + 1));
                    step();
                end

        // ALU path with r0 destination
        mem_to_reg_in = 0; alu_result_in = 32'h00001234; write_reg_in = 5'd0;
        step();
        check("alu_wb", wb_data_out, 32'h00001234);
        check("alu_r0_we", 32'(reg_write_out), 32'h0);

        // Stall holds value A and the counter
        load(2'b10, 0, 2'd0, 32'h11223344, 5'd5);
        step();
        cnt_saved = m_cnt;
        stall = 1;
        load(2'b00, 1, 2'd1, 32'hAAAA5555, 5'd12);
        valid_in = 0;
        repeat (3) step();
        check("stall_wb", wb_data_out, 32'h11223344);
        check("stall_wr", 32'(write_reg_out), 32'd5);
        check("stall_cnt", 32'(bubble_cnt_out), 32'(cnt_saved));

        // Flush wins over stall; no count while stalled
        flush = 1;
        step();
        check("fs_valid", 32'(valid_out), 32'h0);
        check("fs_we", 32'(reg_write_out), 32'h0);
        check("fs_cnt", 32'(bubble_cnt_out), 32'(cnt_saved));
        stall = 0;
        step();
        check("flush_cnt", 32'(bubble_cnt_out), 32'(cnt_saved + 1));
        flush = 0;

        // Asynchronous reset between edges while valid
        load(2'b10, 0, 2'd0, 32'h0BADF00D, 5'd4);
        step();
        check("pre_rst_valid", 32'(valid_out), 32'h1);
        #2 rst = 1;
        #1;
        check("arst_valid", 32'(valid_out), 32'h0);
        check("arst_wb", wb_data_out, 32'h0);
        check("arst_we", 32'(reg_write_out), 32'h0);
        check("arst_cnt", 32'(bubble_cnt_out), 32'h0);
        #3 rst = 0;
        load(2'b10, 0, 2'd0, 32'hCAFEF00D, 5'd3);
        step();
        check("post_rst_wb", wb_data_out, 32'hCAFEF00D);
        check("post_rst_valid", 32'(valid_out), 32'h1);

        // Counter saturation
        valid_in = 0;
        repeat (20) step();
        check("cnt_sat", 32'(bubble_cnt_out), 32'd15);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_wb_pipe_reg

`default_nettype wire

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
- Parametrised MEM/WB pipeline register for the pipelined processor. Sits between the data-memory stage and the register-file write port.
- Adds stall/flush control, a valid bit, load sub-word extraction, write-back data selection, forwarding outputs and a saturating bubble counter.

Parameters:
- DATA_W, 32, datapath width in bits; multiple of 8, at least 32
- REG_ADDR_W, 5, register-file address width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold all stage registers
- flush  in  1  invalidate the stage (insert bubble)
- valid_in  in  1  MEM stage holds a real instruction
- reg_write_in  in  1  instruction writes the register file
- mem_to_reg_in  in  1  1 = write-back from memory data, 0 = from ALU result
- mem_size_in  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- mem_unsigned_in  in  1  zero-extend sub-word loads
- addr_lo_in  in  2  low bits of the load address
- read_data_in  in  DATA_W  raw memory read word
- alu_result_in  in  DATA_W  ALU result
- write_reg_in  in  REG_ADDR_W  destination register
- valid_out  out  1  registered valid
- reg_write_out  out  1  gated write enable
- mem_to_reg_out  out  1  registered select
- read_data_out  out  DATA_W  registered raw read word
- alu_result_out  out  DATA_W  registered ALU result
- write_reg_out  out  REG_ADDR_W  registered destination
- wb_data_out  out  DATA_W  final write-back value
- fwd_en_out  out  1  forwarding source active
- bubble_cnt_out  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset (async, rst=1): every registered field goes to 0, including valid, write enable, select, size, unsigned, addr_lo, data, destination and counter. As a result every output is 0 while rst is high.
- Each rising clk edge applies the first matching rule, in this priority:
  1. rst
  2. flush: valid=0 and reg_write=0; data, destination and size fields are left unchanged
  3. stall: all fields hold
  4. otherwise: capture all inputs; valid takes valid_in, mem_to_reg takes mem_to_reg_in
- Latency: exactly 1 cycle from input to registered output.
- flush and stall asserted in the same cycle: flush wins.
- reg_write_out = valid & reg_write_r & (write_reg_r != 0). Register 0 is never written.
- fwd_en_out equals reg_write_out.
- Load extraction (combinational from registered fields):
  - Byte lane = addr_lo_r; big-endian is not supported.
  - Half lane = addr_lo_r[1]; addr_lo_r[0] is ignored for halves (misaligned access is not trapped).
  - Result is zero- or sign-extended to DATA_W according to unsigned_r.
  - Word returns read_data_r unchanged.
- wb_data_out = mem_to_reg_r ? extracted load value : alu_result_r.
- Bubble counter:
  - Increments on each clk edge, outside reset, where the post-edge valid is 0 and stall=0.
  - Saturates at all-ones; no wrap.
  - Stall cycles are not counted.

Decomposition:
- Shared package cpu_pkg holds:
  - mem_size_t encodings (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10)
  - DATA_W and REG_ADDR_W defaults
- One sub-module: load_align. It is purely combinational: (word, size, unsigned, addr_lo) -> extended value. The EX/MEM stage reuses it later.

Test Plan:
- Reset mid-operation: rst pulsed asynchronously between clock edges while valid_out=1 -> all outputs 0 immediately, before the next edge. After release, the first capture appears 1 cycle later.
- Word pass-through: valid_in=1, reg_write_in=1, mem_to_reg_in=1, size=10, read_data_in=0xDEADBEEF, write_reg_in=7 -> next cycle wb_data_out=0xDEADBEEF, reg_write_out=1, fwd_en_out=1.
- Sub-word loads with read_data_in=0x80FF7F01:
  - byte, addr_lo=3, signed -> 0xFFFFFF80
  - byte, addr_lo=0, unsigned -> 0x00000001
  - half, addr_lo=2, signed -> 0xFFFF80FF
  - half, addr_lo=0, unsigned -> 0x00007F01
- ALU path: mem_to_reg_in=0, alu_result_in=0x00001234, write_reg_in=0 -> wb_data_out=0x1234, reg_write_out=0 (r0 guard).
- Stall/flush:
  - Load a value A, then stall 3 cycles with different inputs -> outputs hold A and the counter is unchanged.
  - Assert flush and stall together -> valid_out=0, reg_write_out=0; counter +1 only on a non-stalled bubble edge.
- Counter saturation: CNT_W=4, valid_in=0 for 20 cycles -> bubble_cnt_out sticks at 15.
